// File: rtl/paint_ctrl_brush_pkg.sv
// Shared types and helpers for the retro_paint brush sequencer.
// Optional erase support is selected by the PAINT_ERASE_EN macro in paint_ctrl_brush.sv.
package paint_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_DECODE,
    ST_CURSOR,
    ST_PAL,
    ST_PAL_CHK,
    ST_PAL_COMMIT,
    ST_PAINT
  } paint_state_t;

  localparam int ERASE_COLOR = 0;

  // A zero-sized brush would paint nothing, so the smallest legal side is one pixel.
  function automatic int clamp_side(input int side, input int side_max);
    if (side < 1) return 1;
    if (side > side_max) return side_max;
    return side;
  endfunction

endpackage

// File: rtl/paint_ctrl_brush_if.sv
// Framebuffer pixel write port: valid/ready handshake carrying coordinates and colour.
interface paint_ctrl_brush_if #(
  parameter int CW  = 8,
  parameter int PXW = 8
) ();

  logic           wr_valid;
  logic           wr_ready;
  logic [CW-1:0]  wr_x;
  logic [CW-1:0]  wr_y;
  logic [PXW-1:0] wr_data;

  modport master (output wr_valid, wr_x, wr_y, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_x, wr_y, wr_data, output wr_ready);

endinterface

// File: rtl/paint_ctrl_brush_walker.sv
// Raster walker over an NxN brush: dx/dy counters, on-screen test and last-pixel flag.
module paint_brush_walker #(
  parameter int CW    = 8,
  parameter int SCR_W = 64,
  parameter int SCR_H = 64,
  parameter int BW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          advance,
  input  logic [CW-1:0] x0,
  input  logic [CW-1:0] y0,
  input  logic [BW-1:0] side,
  output logic [CW-1:0] px_x,
  output logic [CW-1:0] px_y,
  output logic          px_on,
  output logic          last
);

  logic [BW-1:0] dx;
  logic [BW-1:0] dy;
  logic [CW:0]   sum_x;
  logic [CW:0]   sum_y;
  logic          row_end;

  assign row_end = (dx == side - BW'(1));

  always_ff @(posedge clk) begin
    if (rst || start) begin
      dx <= '0;
      dy <= '0;
    end else if (advance) begin
      if (row_end) begin
        dx <= '0;
        dy <= dy + BW'(1);
      end else begin
        dx <= dx + BW'(1);
      end
    end
  end

  // One extra bit keeps a cursor near the top of the coordinate range from wrapping back on-screen.
  assign sum_x = {1'b0, x0} + (CW+1)'(dx);
  assign sum_y = {1'b0, y0} + (CW+1)'(dy);
  assign px_on = (sum_x < (CW+1)'(SCR_W)) && (sum_y < (CW+1)'(SCR_H));
  assign px_x  = sum_x[CW-1:0];
  assign px_y  = sum_y[CW-1:0];
  assign last  = row_end && (dy == side - BW'(1));

endmodule

// File: rtl/paint_ctrl_brush.sv
// Paint-mode sequencer: cursor/palette handshakes and clipped NxN brush painting.
// Define PAINT_ERASE_EN to let btn_erase paint ERASE_COLOR.
module paint_ctrl_brush
  import paint_pkg::*;
#(
  parameter int CW        = 8,
  parameter int PXW       = 8,
  parameter int SCR_W     = 64,
  parameter int SCR_H     = 64,
  parameter int BRUSH_MAX = 4,
  parameter int BW        = $clog2(BRUSH_MAX + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init,
  input  logic [CW-1:0]       cur_x,
  input  logic [CW-1:0]       cur_y,
  input  logic [BW-1:0]       brush_side,
  input  logic                btn_pal,
  input  logic                btn_enter,
  input  logic                btn_erase,
  input  logic [PXW-1:0]      pal_idx,
  input  logic                pal_enter,
  output logic                cursor_req,
  input  logic                cursor_done,
  output logic                pal_req,
  input  logic                pal_done,
  paint_ctrl_brush_if.master  wr,
  output logic [PXW-1:0]      color,
  output logic                busy
);

  paint_state_t  state;
  logic [CW-1:0] x0;
  logic [CW-1:0] y0;
  logic [BW-1:0] side;
  logic          pal_l;
  logic          paint_l;
  logic          erase_l;
  logic          walk_done;
  logic [CW-1:0] px_x;
  logic [CW-1:0] px_y;
  logic          px_on;
  logic          last;
  logic          advance;

`ifndef PAINT_ERASE_EN
  logic unused_erase;
  assign unused_erase = btn_erase;
`endif

  // The walker moves on whenever the output slot is free or its current beat is being accepted.
  assign advance = (state == ST_PAINT) && !walk_done && (!wr.wr_valid || wr.wr_ready);
  assign busy    = (state != ST_IDLE);

  paint_brush_walker #(
    .CW   (CW),
    .SCR_W(SCR_W),
    .SCR_H(SCR_H),
    .BW   (BW)
  ) u_walker (
    .clk    (clk),
    .rst    (rst),
    .start  (state == ST_DECODE),
    .advance(advance),
    .x0     (x0),
    .y0     (y0),
    .side   (side),
    .px_x   (px_x),
    .px_y   (px_y),
    .px_on  (px_on),
    .last   (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      color       <= '0;
      cursor_req  <= 1'b0;
      pal_req     <= 1'b0;
      wr.wr_valid <= 1'b0;
      wr.wr_x     <= '0;
      wr.wr_y     <= '0;
      wr.wr_data  <= '0;
      x0          <= '0;
      y0          <= '0;
      side        <= '0;
      pal_l       <= 1'b0;
      paint_l     <= 1'b0;
      erase_l     <= 1'b0;
      walk_done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (init) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          x0        <= cur_x;
          y0        <= cur_y;
          side      <= BW'(clamp_side(int'(brush_side), BRUSH_MAX));
          pal_l     <= btn_pal;
          walk_done <= 1'b0;
`ifdef PAINT_ERASE_EN
          paint_l   <= btn_enter | btn_erase;
          erase_l   <= btn_erase & ~btn_enter;
`else
          paint_l   <= btn_enter;
          erase_l   <= 1'b0;
`endif
          state     <= ST_DECODE;
        end
        ST_DECODE: begin
          if (pal_l) begin
            pal_req <= 1'b1;
            state   <= ST_PAL;
          end else if (paint_l) begin
            state <= ST_PAINT;
          end else begin
            cursor_req <= 1'b1;
            state      <= ST_CURSOR;
          end
        end
        ST_CURSOR: begin
          if (cursor_done) begin
            cursor_req <= 1'b0;
            state      <= ST_SAMPLE;
          end
        end
        ST_PAL: begin
          if (pal_done) begin
            pal_req <= 1'b0;
            state   <= ST_PAL_CHK;
          end
        end
        ST_PAL_CHK: begin
          if (pal_enter) begin
            state <= ST_PAL_COMMIT;
          end else begin
            pal_req <= 1'b1;
            state   <= ST_PAL;
          end
        end
        ST_PAL_COMMIT: begin
          color <= pal_idx;
          state <= ST_SAMPLE;
        end
        ST_PAINT: begin
          // A stalled beat holds its coordinates and data until the framebuffer takes it.
          if (!wr.wr_valid || wr.wr_ready) begin
            if (walk_done) begin
              wr.wr_valid <= 1'b0;
              state       <= ST_SAMPLE;
            end else begin
              wr.wr_valid <= px_on;
              if (px_on) begin
                wr.wr_x    <= px_x;
                wr.wr_y    <= px_y;
                wr.wr_data <= erase_l ? PXW'(ERASE_COLOR) : color;
              end
              if (last) begin
                if (px_on) walk_done <= 1'b1;
                else       state     <= ST_SAMPLE;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_paint_ctrl_brush.sv
// Self-checking bench for paint_ctrl_brush: directed tables, palette/reset sequences and random brushes.
// Honours PAINT_ERASE_EN the same way as the design.
module tb_paint_ctrl_brush;
  import paint_pkg::*;

  localparam int CW        = 8;
  localparam int PXW       = 8;
  localparam int SCR_W     = 64;
  localparam int SCR_H     = 64;
  localparam int BRUSH_MAX = 4;
  localparam int BW        = $clog2(BRUSH_MAX + 1);
`ifdef PAINT_ERASE_EN
  localparam bit ERASE_EN = 1'b1;
`else
  localparam bit ERASE_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] d;
  } pix_t;

  typedef struct {
    int x;
    int y;
    int side;
    bit enter;
    bit erase;
    int mode;
    int exp_n;
  } vec_t;

  logic           clk;
  logic           rst;
  logic           init;
  logic [CW-1:0]  cur_x;
  logic [CW-1:0]  cur_y;
  logic [BW-1:0]  brush_side;
  logic           btn_pal;
  logic           btn_enter;
  logic           btn_erase;
  logic [PXW-1:0] pal_idx;
  logic           pal_enter;
  logic           cursor_req;
  logic           cursor_done;
  logic           pal_req;
  logic           pal_done;
  logic [PXW-1:0] color;
  logic           busy;

  int   pass_cnt  = 0;
  int   check_cnt = 0;
  int   rdy_mode  = 0;
  int   color_m   = 0;
  pix_t got_q[$];
  pix_t exp_q[$];
  bit   stall_prev = 1'b0;
  pix_t prev_pix;
  vec_t vecs[9];

  paint_ctrl_brush_if #(.CW(CW), .PXW(PXW)) wr_bus ();

  paint_ctrl_brush #(
    .CW       (CW),
    .PXW      (PXW),
    .SCR_W    (SCR_W),
    .SCR_H    (SCR_H),
    .BRUSH_MAX(BRUSH_MAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .init       (init),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .brush_side (brush_side),
    .btn_pal    (btn_pal),
    .btn_enter  (btn_enter),
    .btn_erase  (btn_erase),
    .pal_idx    (pal_idx),
    .pal_enter  (pal_enter),
    .cursor_req (cursor_req),
    .cursor_done(cursor_done),
    .pal_req    (pal_req),
    .pal_done   (pal_done),
    .wr         (wr_bus),
    .color      (color),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Ready pattern is chosen per test: always ready, coin-flip, or held low.
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       wr_bus.wr_ready = 1'b1;
      1:       wr_bus.wr_ready = 1'($urandom_range(0, 1));
      default: wr_bus.wr_ready = 1'b0;
    endcase
  end

  // Inputs settle at posedge+2, so the negedge view equals what the next rising edge sees.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev)
        checkOutput("hold_stable",
                    {7'b0, wr_bus.wr_valid, wr_bus.wr_x, wr_bus.wr_y, wr_bus.wr_data},
                    {7'b0, 1'b1, prev_pix});
      if (wr_bus.wr_valid && wr_bus.wr_ready)
        got_q.push_back({wr_bus.wr_x, wr_bus.wr_y, wr_bus.wr_data});
      stall_prev <= wr_bus.wr_valid && !wr_bus.wr_ready;
      prev_pix   <= {wr_bus.wr_x, wr_bus.wr_y, wr_bus.wr_data};
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic waitFor(input int which, input string name);
    for (int i = 0; i < 3000; i++) begin
      if ((which == 0 && cursor_req) || (which == 1 && pal_req) || (which == 2 && wr_bus.wr_valid))
        return;
      tick();
    end
    checkOutput({"timeout_", name}, 0, 1);
  endtask

  // Reference model: every brush pixel in raster order, minus those falling off the screen.
  task automatic buildExpected(input int x, input int y, input int side, input bit enter, input bit erase);
    int s;
    int d;
    exp_q.delete();
    if (!(enter || (ERASE_EN && erase))) return;
    s = (side == 0) ? 1 : (side > BRUSH_MAX) ? BRUSH_MAX : side;
    d = (!enter && erase) ? ERASE_COLOR : color_m;
    for (int dy = 0; dy < s; dy++)
      for (int dx = 0; dx < s; dx++)
        if (x + dx < SCR_W && y + dy < SCR_H)
          exp_q.push_back({8'(x + dx), 8'(y + dy), 8'(d)});
  endtask

  // Expects the DUT parked in CURSOR; releases it into one SAMPLE with the given buttons.
  task automatic applyStimulus(input int x, input int y, input int side, input bit enter,
                               input bit erase, input bit pal, input int mode);
    rdy_mode    = mode;
    cur_x       = 8'(x);
    cur_y       = 8'(y);
    brush_side  = BW'(side);
    btn_enter   = enter;
    btn_erase   = erase;
    btn_pal     = pal;
    cursor_done = 1'b1;
    tick();
    cursor_done = 1'b0;
    tick(2);
    btn_enter   = 1'b0;
    btn_erase   = 1'b0;
    btn_pal     = 1'b0;
  endtask

  task automatic runPaint(input string name, input int x, input int y, input int side,
                          input bit enter, input bit erase, input int mode, input int exp_n);
    got_q.delete();
    buildExpected(x, y, side, enter, erase);
    applyStimulus(x, y, side, enter, erase, 1'b0, mode);
    waitFor(0, name);
    if (exp_n >= 0) checkOutput({name, "_count_tbl"}, got_q.size(), exp_n);
    checkOutput({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      checkOutput({name, "_pix"}, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic runPalette(input int v, input bit reject_first);
    int old = color_m;
    applyStimulus(0, 0, 1, 1'b0, 1'b0, 1'b1, 0);
    waitFor(1, "pal_req");
    if (reject_first) begin
      pal_enter = 1'b0;
      pal_done  = 1'b1;
      tick();
      pal_done  = 1'b0;
      checkOutput("pal_req_drop", pal_req, 0);
      tick();
      checkOutput("pal_reject_req", pal_req, 1);
      checkOutput("pal_reject_color", color, old);
    end
    pal_idx   = 8'(v);
    pal_enter = 1'b1;
    pal_done  = 1'b1;
    tick();
    pal_done  = 1'b0;
    tick();
    checkOutput("pal_before_commit", color, old);
    tick();
    pal_enter = 1'b0;
    checkOutput("pal_commit", color, v);
    color_m = v;
    waitFor(0, "pal_back");
  endtask

  initial begin
    rst = 1'b1; init = 1'b0; cur_x = '0; cur_y = '0; brush_side = '0;
    btn_pal = 1'b0; btn_enter = 1'b0; btn_erase = 1'b0; pal_idx = '0;
    pal_enter = 1'b0; cursor_done = 1'b0; pal_done = 1'b0;
    wr_bus.wr_ready = 1'b1;

    vecs[0] = '{10, 20, 3, 1'b1, 1'b0, 0, 9};
    vecs[1] = '{62, 63, 4, 1'b1, 1'b0, 0, 2};
    vecs[2] = '{0, 0, 0, 1'b1, 1'b0, 0, 1};
    vecs[3] = '{5, 5, 7, 1'b1, 1'b0, 1, 16};
    vecs[4] = '{60, 61, 4, 1'b1, 1'b0, 1, 12};
    vecs[5] = '{255, 254, 4, 1'b1, 1'b0, 0, 0};
    vecs[6] = '{64, 10, 2, 1'b1, 1'b0, 0, 0};
    vecs[7] = '{10, 10, 2, 1'b0, 1'b1, 0, ERASE_EN ? 4 : 0};
    vecs[8] = '{20, 30, 2, 1'b1, 1'b1, 1, 4};

    tick(3);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_valid", wr_bus.wr_valid, 0);
    checkOutput("rst_color", color, 0);
    checkOutput("rst_cursor_req", cursor_req, 0);
    checkOutput("rst_pal_req", pal_req, 0);
    checkOutput("rst_wr_xyd", {8'h0, wr_bus.wr_x, wr_bus.wr_y, wr_bus.wr_data}, 0);
    rst = 1'b0;
    tick(2);
    checkOutput("idle_hold", busy, 0);

    init = 1'b1;
    tick();
    init = 1'b0;
    checkOutput("init_busy", busy, 1);
    waitFor(0, "first_cursor");
    checkOutput("cursor_color", color, 0);
    cursor_done = 1'b1;
    tick();
    cursor_done = 1'b0;
    checkOutput("cursor_req_drop", cursor_req, 0);
    waitFor(0, "cursor_again");
    checkOutput("cursor_req_again", cursor_req, 1);

    runPalette(8'h5A, 1'b1);

    for (int i = 0; i < 9; i++)
      runPaint($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].side,
               vecs[i].enter, vecs[i].erase, vecs[i].mode, vecs[i].exp_n);

    runPalette(8'hC3, 1'b0);
    for (int i = 0; i < 24; i++)
      runPaint($sformatf("rnd%0d", i), $urandom_range(0, 70), $urandom_range(0, 70),
               $urandom_range(0, 7), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               $urandom_range(0, 1), -1);

    got_q.delete();
    applyStimulus(1, 2, 4, 1'b1, 1'b0, 1'b0, 2);
    waitFor(2, "stall_valid");
    tick(3);
    checkOutput("stall_valid_held", wr_bus.wr_valid, 1);
    rst = 1'b1;
    tick();
    checkOutput("midrst_valid", wr_bus.wr_valid, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_color", color, 0);
    checkOutput("midrst_cursor_req", cursor_req, 0);
    rst = 1'b0;
    rdy_mode = 0;
    tick(4);
    checkOutput("postrst_valid", wr_bus.wr_valid, 0);
    checkOutput("postrst_idle", busy, 0);
    checkOutput("postrst_no_writes", got_q.size(), 0);

    $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
